// File: rtl/footswitch_events_if.sv
// rtl/footswitch_events_if.sv - footswitch pin inputs and press-event outputs
// Signals:
//   btn_pin_1     [NUM_BTNS] NO contact per channel, low = closed
//   btn_pin_2     [NUM_BTNS] NC contact per channel, low = closed
//   midi_in_state [2]        MIDI receiver state, 1 = message captured
//   evt_valid                one-cycle event strobe
//   evt_index     [IDX_W]    1-based channel of the event, 0 when idle
//   evt_long                 event is a long press
//   save_mode                MIDI capture flag qualified by evt_valid
// Modports: master = board/controller side, slave = footswitch_events.
interface footswitch_events_if #(
  parameter int NUM_BTNS = 4,
  parameter int IDX_W    = 3
);
  logic [NUM_BTNS-1:0] btn_pin_1;
  logic [NUM_BTNS-1:0] btn_pin_2;
  logic [1:0]          midi_in_state;
  logic                evt_valid;
  logic [IDX_W-1:0]    evt_index;
  logic                evt_long;
  logic                save_mode;

  modport master (
    output btn_pin_1, btn_pin_2, midi_in_state,
    input  evt_valid, evt_index, evt_long, save_mode
  );

  modport slave (
    input  btn_pin_1, btn_pin_2, midi_in_state,
    output evt_valid, evt_index, evt_long, save_mode
  );
endinterface

// File: rtl/footswitch_events.sv
// rtl/footswitch_events.sv - N-channel SPDT footswitch debounce and event serialiser
// Ports:
//   clk  single clock
//   rst  asynchronous active-high reset
//   bus  footswitch_events_if.slave: pins and MIDI state in, press events out
// Build option: define LONG_PRESS_EN to add long-press detection; without it
// evt_long is tied low and no hold counter or owner register exist.
module footswitch_events #(
  parameter int NUM_BTNS        = 4,
  parameter int IDX_W           = 3,
  parameter int DEBOUNCE_CYCLES = 2048,
  parameter int LONG_CYCLES     = 500000
) (
  input  logic               clk,
  input  logic               rst,
  footswitch_events_if.slave bus
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronisers on every contact.
  logic [NUM_BTNS-1:0] pin1_meta;
  logic [NUM_BTNS-1:0] pin1_sync;
  logic [NUM_BTNS-1:0] pin2_meta;
  logic [NUM_BTNS-1:0] pin2_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pin1_meta <= '0;
      pin1_sync <= '0;
      pin2_meta <= '0;
      pin2_sync <= '0;
    end else begin
      pin1_meta <= bus.btn_pin_1;
      pin1_sync <= pin1_meta;
      pin2_meta <= bus.btn_pin_2;
      pin2_sync <= pin2_meta;
    end
  end

  logic [NUM_BTNS-1:0] pressed;
  logic [NUM_BTNS-1:0] pressed_q;
  logic [NUM_BTNS-1:0] rise;
  logic [NUM_BTNS-1:0] pending;

  // Break-before-make debounce: only the full opposite pattern counts toward
  // a flip; 00 and 11 (mid-throw or both contacts bridged) hold the state
  // but restart the count.
  for (genvar k = 0; k < NUM_BTNS; k++) begin : g_chan
    logic [CNT_W-1:0] cnt;
    logic             pressed_r;
    logic             press_pat;
    logic             release_pat;
    logic             toward;

    assign press_pat   = ~pin1_sync[k] &  pin2_sync[k];
    assign release_pat =  pin1_sync[k] & ~pin2_sync[k];
    assign toward      = pressed_r ? release_pat : press_pat;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt       <= '0;
        pressed_r <= 1'b0;
      end else if (toward) begin
        if (cnt == CNT_LAST) begin
          pressed_r <= ~pressed_r;
          cnt       <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end

    assign pressed[k] = pressed_r;
  end

  assign rise = pressed & ~pressed_q;

  // Lowest pending channel wins; the rest wait for later cycles.
  logic                grant_any;
  logic [IDX_W-1:0]    grant_idx;
  logic [NUM_BTNS-1:0] grant_mask;

  always_comb begin
    grant_any  = |pending;
    grant_idx  = '0;
    grant_mask = '0;
    for (int i = NUM_BTNS - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant_idx  = IDX_W'(i + 1);
        grant_mask = NUM_BTNS'(1) << i;
      end
    end
  end

  // A rise on a bit that is still pending simply merges into it; a rise on
  // the bit being granted this cycle re-arms it as a fresh event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pressed_q <= '0;
      pending   <= '0;
    end else begin
      pressed_q <= pressed;
      pending   <= (pending & ~grant_mask) | rise;
    end
  end

  logic midi_hit;
  assign midi_hit = (bus.midi_in_state == 2'd1);

  logic             long_fire;
  logic [IDX_W-1:0] long_idx;

`ifdef LONG_PRESS_EN
  localparam int                HOLD_W    = $clog2(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [IDX_W-1:0]  owner;
  logic [HOLD_W-1:0] hold;
  logic              owner_pressed;
  logic              long_req;
  logic              evt_long_r;

  always_comb begin
    owner_pressed = 1'b0;
    for (int i = 0; i < NUM_BTNS; i++) begin
      if (owner == IDX_W'(i + 1)) begin
        owner_pressed = pressed[i];
      end
    end
  end

  assign long_req  = (owner != '0) && owner_pressed && (hold == HOLD_LAST);
  assign long_fire = long_req && !grant_any;
  assign long_idx  = owner;

  // A short event from the owner itself while its long event is due leaves
  // the counter parked so the long event goes out next cycle; any other
  // short event takes ownership and restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner <= '0;
      hold  <= '0;
    end else if (grant_any) begin
      if (!(long_req && grant_idx == owner)) begin
        owner <= grant_idx;
        hold  <= '0;
      end
    end else if (long_req) begin
      owner <= '0;
      hold  <= '0;
    end else if (owner != '0) begin
      if (!owner_pressed) begin
        owner <= '0;
        hold  <= '0;
      end else begin
        hold <= hold + HOLD_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_long_r <= 1'b0;
    end else begin
      evt_long_r <= long_fire;
    end
  end

  assign bus.evt_long = evt_long_r;
`else
  assign long_fire    = 1'b0;
  assign long_idx     = '0;
  assign bus.evt_long = 1'b0;
`endif

  logic             evt_valid_r;
  logic [IDX_W-1:0] evt_index_r;
  logic             save_mode_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid_r <= 1'b0;
      evt_index_r <= '0;
      save_mode_r <= 1'b0;
    end else begin
      evt_valid_r <= 1'b0;
      evt_index_r <= '0;
      save_mode_r <= 1'b0;
      if (grant_any) begin
        evt_valid_r <= 1'b1;
        evt_index_r <= grant_idx;
        save_mode_r <= midi_hit;
      end else if (long_fire) begin
        evt_valid_r <= 1'b1;
        evt_index_r <= long_idx;
        save_mode_r <= midi_hit;
      end
    end
  end

  assign bus.evt_valid = evt_valid_r;
  assign bus.evt_index = evt_index_r;
  assign bus.save_mode = save_mode_r;

endmodule

// File: tb/tb_footswitch_events.sv
// tb/tb_footswitch_events.sv - self-checking bench for footswitch_events
module tb_footswitch_events;
  localparam int         NB = 4;
  localparam int         IW = 3;
  localparam int         DB = 8;
  localparam int         LC = 100;
  localparam logic [1:0] PR = 2'b01;  // {pin_1, pin_2} press pattern
  localparam logic [1:0] RL = 2'b10;  // release pattern

  logic clk = 1'b0;
  logic rst = 1'b1;

  footswitch_events_if #(.NUM_BTNS(NB), .IDX_W(IW)) bus ();

  footswitch_events #(
    .NUM_BTNS(NB), .IDX_W(IW), .DEBOUNCE_CYCLES(DB), .LONG_CYCLES(LC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n     = 0;

  logic [1:0] pat [NB];
  logic [1:0] hist [NB][8192];
  logic [1:0] midi = 2'd0;

  // Reference model: pressed flips once the last DB synchronised samples
  // all show the opposite pattern; presses queue and drain lowest first.
  bit m_pressed [NB];
  bit m_prev    [NB];
  bit m_pending [NB];
  int l_owner = 0;
  int l_due   = 0;

  typedef struct { int cyc; int idx; bit lng; bit save; } evt_t;
  evt_t ev_log [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, n);
    end
  endtask

  task automatic step();
    int         found;
    bit         stable;
    logic [1:0] tgt;
    int         ev, ei, el, es;
    logic [NB-1:0] p1, p2;
    for (int k = 0; k < NB; k++) begin
      p1[k] = pat[k][1];
      p2[k] = pat[k][0];
    end
    bus.btn_pin_1     = p1;
    bus.btn_pin_2     = p2;
    bus.midi_in_state = midi;
    ev = 0; ei = 0; el = 0; es = 0;
    if (rst) begin
      for (int k = 0; k < NB; k++) begin
        hist[k][n] = 2'b00;
        if (n > 0) hist[k][n-1] = 2'b00;
        m_pressed[k] = 1'b0;
        m_prev[k]    = 1'b0;
        m_pending[k] = 1'b0;
      end
      l_owner = 0;
    end else begin
      for (int k = 0; k < NB; k++) hist[k][n] = pat[k];
      found = -1;
      for (int k = NB - 1; k >= 0; k--) if (m_pending[k]) found = k;
      if (found >= 0) begin
        ev = 1; ei = found + 1; es = (midi == 2'd1) ? 1 : 0;
`ifdef LONG_PRESS_EN
        if (l_owner == found + 1 && l_due == n && m_pressed[found]) l_due = n + 1;
        else begin
          l_owner = found + 1;
          l_due   = n + LC;
        end
`endif
        m_pending[found] = 1'b0;
      end
`ifdef LONG_PRESS_EN
      else if (l_owner != 0) begin
        if (!m_pressed[l_owner-1]) l_owner = 0;
        else if (n == l_due) begin
          ev = 1; ei = l_owner; el = 1; es = (midi == 2'd1) ? 1 : 0;
          l_owner = 0;
        end
      end
`endif
      for (int k = 0; k < NB; k++) begin
        if (m_pressed[k] && !m_prev[k]) m_pending[k] = 1'b1;
        m_prev[k] = m_pressed[k];
        tgt    = m_pressed[k] ? RL : PR;
        stable = 1'b1;
        for (int j = 0; j < DB; j++)
          if (n - 2 - j < 0 || hist[k][n-2-j] !== tgt) stable = 1'b0;
        if (stable) m_pressed[k] = !m_pressed[k];
      end
    end
    @(posedge clk);
    #1;
    check("evt_valid", bus.evt_valid, ev);
    check("evt_index", bus.evt_index, ei);
    check("evt_long", bus.evt_long, el);
    check("save_mode", bus.save_mode, es);
    if (bus.evt_valid === 1'b1)
      ev_log.push_back('{cyc: n, idx: int'(bus.evt_index), lng: bus.evt_long, save: bus.save_mode});
    n++;
  endtask

  task automatic run(input int cnt);
    for (int i = 0; i < cnt; i++) step();
  endtask

  function automatic logic [1:0] rand_pat();
    int r;
    r = $urandom_range(0, 9);
    if (r < 4) return PR;
    if (r < 8) return RL;
    if (r == 8) return 2'b00;
    return 2'b11;
  endfunction

  initial begin
    int t;
    for (int k = 0; k < NB; k++) pat[k] = RL;

    // reset state
    run(3);
    rst = 1'b0;
    run(12);

    // chatter then stable press on channel 2
    ev_log.delete();
    for (int i = 0; i < 5; i++) begin
      pat[2] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
      step();
    end
    pat[2] = PR;
    t = n - 1;
    run(20);
    check("chatter_count", ev_log.size(), 1);
    check("chatter_idx", ev_log[0].idx, 3);
    check("chatter_time", ev_log[0].cyc, t + 12);
    ev_log.delete();
    pat[2] = RL;
    run(20);
    check("release_no_evt", ev_log.size(), 0);

    // one short of debounce, repeated
    for (int i = 0; i < 20; i++) begin
      pat[0] = PR;
      run(DB - 1);
      pat[0] = ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11;
      run(1);
    end
    pat[0] = RL;
    run(12);
    check("bounce_no_evt", ev_log.size(), 0);

    // simultaneous presses serialise in ascending order
    pat[3] = PR;
    pat[1] = PR;
    t = n - 1;
    run(16);
    check("simul_count", ev_log.size(), 2);
    check("simul_first", ev_log[0].idx, 2);
    check("simul_second", ev_log[1].idx, 4);
    check("simul_t1", ev_log[0].cyc, t + 12);
    check("simul_t2", ev_log[1].cyc, t + 13);
    pat[3] = RL;
    pat[1] = RL;
    run(16);
    ev_log.delete();

    // save_mode follows midi_in_state == 1
    midi   = 2'd1;
    pat[0] = PR;
    run(16);
    pat[0] = RL;
    run(16);
    midi   = 2'd2;
    pat[0] = PR;
    run(16);
    pat[0] = RL;
    run(16);
    check("midi_count", ev_log.size(), 2);
    check("midi_save1", ev_log[0].save, 1);
    check("midi_save2", ev_log[1].save, 0);
    midi = 2'd0;
    ev_log.delete();

    // hold for 150 cycles
    pat[0] = PR;
    run(150);
    pat[0] = RL;
    run(20);
`ifdef LONG_PRESS_EN
    check("long_count", ev_log.size(), 2);
    check("long_short_idx", ev_log[0].idx, 1);
    check("long_short_flag", ev_log[0].lng, 0);
    check("long_idx", ev_log[1].idx, 1);
    check("long_flag", ev_log[1].lng, 1);
    check("long_delay", ev_log[1].cyc - ev_log[0].cyc, LC);
    ev_log.delete();
    pat[0] = PR;
    run(12 + 60);
    pat[0] = RL;
    run(150);
    check("early_release_count", ev_log.size(), 1);
    check("early_release_flag", ev_log[0].lng, 0);
`else
    check("hold_count", ev_log.size(), 1);
    check("hold_flag", ev_log[0].lng, 0);
`endif
    ev_log.delete();

    // reset with ch1 pending and ch2 held
    pat[2] = PR;
    run(16);
    ev_log.delete();
    pat[1] = PR;
    run(DB + 3);
    rst = 1'b1;
    #1;
    check("rst_valid", bus.evt_valid, 0);
    check("rst_index", bus.evt_index, 0);
    check("rst_save", bus.save_mode, 0);
    pat[1] = RL;
    run(3);
    rst = 1'b0;
    t = n - 1;
    run(20);
    check("rst_count", ev_log.size(), 1);
    check("rst_idx", ev_log[0].idx, 3);
    check("rst_time", ev_log[0].cyc, t + 12);
    pat[2] = RL;
    run(16);

    // random chatter, fast changes
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NB; k++)
        if ($urandom_range(0, 11) == 0) pat[k] = rand_pat();
      midi = 2'($urandom_range(0, 3));
      if (i == 700) rst = 1'b1;
      if (i == 703) rst = 1'b0;
      step();
    end
    rst = 1'b0;

    // random slow changes, reaches long holds
    for (int i = 0; i < 1500; i++) begin
      for (int k = 0; k < NB; k++)
        if ($urandom_range(0, 119) == 0) pat[k] = ($urandom_range(0, 1) != 0) ? PR : RL;
      midi = 2'($urandom_range(0, 3));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
